mul_seq_controller: RTL and testbench

- Sequencing controller for the shift-and-add multiplier datapath in the TinyTapeout multiplier designs.
- Captures x/y on a start strobe and steps one multiplier bit per clock through an internal accumulator.
- Presents the product on p with a single-cycle rdy pulse.
- Sits between the io_in decode (y, x, rst, clk) and the io_out encode (p, s, rdy) in the top_mul* wrappers.

---
 rtl/mul_seq_controller.sv | 148 ++++++++++++++
 tb/tb_mul_seq_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_controller.sv
// Sequencing controller for a shift-and-add multiplier: one multiplier bit per clock, product
// presented on p with a one-cycle rdy pulse. Optional sign-magnitude mode: MUL_SIGNED_EN.
module mul_seq_controller #(
    parameter int X_WIDTH   = 3,
    parameter int Y_WIDTH   = 3,
    parameter int P_WIDTH   = X_WIDTH + Y_WIDTH,
    parameter int CNT_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               start,
    output logic [P_WIDTH-1:0] p,
    output logic               s,
    output logic               rdy,
    output logic               busy
);

    // Handshake: start is accepted only on an edge where the controller is IDLE (busy=0, rdy=0).
    // x/y are captured on that edge only. The result is valid on p/s while rdy is high.
    // rdy stays high for exactly one cycle, and p/s hold their value until the next rdy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(Y_WIDTH - 1);

    state_t               state, state_next;
    logic [P_WIDTH-1:0]   acc, acc_next;
    logic [P_WIDTH-1:0]   mcand, mcand_next;
    logic [Y_WIDTH-1:0]   mplier, mplier_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [P_WIDTH-1:0]   p_next;
    logic                 s_next;
    logic                 rdy_next;
    logic                 busy_next;
    logic [P_WIDTH-1:0]   step_sum;
    logic [X_WIDTH-1:0]   x_mag;
    logic [Y_WIDTH-1:0]   y_mag;

`ifdef MUL_SIGNED_EN
    logic sign_q, sign_next;

    // Sign bits are stripped at capture so the step count is the same as in the unsigned build.
    assign x_mag = {1'b0, x[X_WIDTH-2:0]};
    assign y_mag = {1'b0, y[Y_WIDTH-2:0]};
`else
    assign x_mag = x;
    assign y_mag = y;
`endif

    assign step_sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p      <= '0;
            s      <= 1'b0;
            rdy    <= 1'b0;
            busy   <= 1'b0;
`ifdef MUL_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            cnt    <= cnt_next;
            p      <= p_next;
            s      <= s_next;
            rdy    <= rdy_next;
            busy   <= busy_next;
`ifdef MUL_SIGNED_EN
            sign_q <= sign_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        cnt_next    = cnt;
        p_next      = p;
        s_next      = s;
        rdy_next    = 1'b0;
        busy_next   = busy;
`ifdef MUL_SIGNED_EN
        sign_next   = sign_q;
`endif

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    mcand_next  = P_WIDTH'(x_mag);
                    mplier_next = y_mag;
                    acc_next    = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = RUN;
`ifdef MUL_SIGNED_EN
                    sign_next   = x[X_WIDTH-1] ^ y[Y_WIDTH-1];
`endif
                end
            end

            RUN: begin
                busy_next   = 1'b1;
                acc_next    = step_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CNT_WIDTH'(1);
                // The last step publishes the sum including its own partial product.
                if (cnt == LAST_STEP) begin
                    p_next     = step_sum;
`ifdef MUL_SIGNED_EN
                    s_next     = sign_q & (|step_sum);
`else
                    s_next     = 1'b0;
`endif
                    rdy_next   = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_seq_controller.sv
// Self-checking bench for mul_seq_controller: timeline model plus scoreboard queue, and
// directed vectors with hand-computed products and latencies.
module tb_mul_seq_controller;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int PW = XW + YW;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PW-1:0] p;
    logic          s;
    logic          rdy;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries are {s, p} for each accepted operation.
    logic [PW:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mul_seq_controller #(
        .X_WIDTH(XW),
        .Y_WIDTH(YW),
        .P_WIDTH(PW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .start(start),
        .p    (p),
        .s    (s),
        .rdy  (rdy),
        .busy (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one operation from the arithmetic definition.
    function automatic logic [PW:0] ref_result(input logic [XW-1:0] a, input logic [YW-1:0] b);
        int am;
        int bm;
        int prod;
        logic sg;
`ifdef MUL_SIGNED_EN
        am   = int'(a) % (1 << (XW - 1));
        bm   = int'(b) % (1 << (YW - 1));
        prod = am * bm;
        sg   = ((int'(a) >= (1 << (XW - 1))) != (int'(b) >= (1 << (YW - 1)))) && (prod != 0);
`else
        am   = int'(a);
        bm   = int'(b);
        prod = am * bm;
        sg   = 1'b0;
`endif
        return {sg, PW'(prod)};
    endfunction

    // ---------------- behavioural model ----------------
    // Operation occupies Y+2 cycles from acceptance: busy after edges 1..Y+1, rdy after edge Y+1.
    int            m_left = 0;
    logic [PW-1:0] m_p    = '0;
    logic          m_s    = 1'b0;
    logic          m_rdy  = 1'b0;
    logic          m_busy = 1'b0;
    logic [PW:0]   m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_p    = '0;
            m_s    = 1'b0;
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            exp_q.delete();
        end else if (m_left == 0) begin
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            if (start) begin
                m_left = YW + 2 - 1;
                m_busy = 1'b1;
                m_pend = ref_result(x, y);
                exp_q.push_back(m_pend);
            end
        end else begin
            m_left--;
            m_rdy = (m_left == 1);
            if (m_left == 1) {m_s, m_p} = m_pend;
            if (m_left == 0) m_busy = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    logic [PW:0] sb_item;
    always @(posedge clk) begin
        #2;
        chk("p", p, m_p);
        chk("s", s, m_s);
        chk("rdy", rdy, m_rdy);
        chk("busy", busy, m_busy);
        if (rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: rdy=1 with no accepted operation at %0t", $time);
            end else begin
                sb_item = exp_q.pop_front();
                if ({s, p} !== sb_item) begin
                    errors++;
                    $display("FAIL sb_result: got s=%0d p=%0d expected s=%0d p=%0d at %0t",
                             s, p, sb_item[PW], sb_item[PW-1:0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [XW-1:0] xv, input logic [YW-1:0] yv,
                         output int lat, output logic [PW-1:0] pv, output logic sv);
        @(negedge clk);
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (rdy !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        pv = p;
        sv = s;
    endtask

    int            lat;
    logic [PW-1:0] pv;
    logic          sv;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (5) @(negedge clk);
        chk("t1_p", p, 0);
        chk("t1_busy", busy, 0);
        chk("t1_rdy", rdy, 0);

        // 7*7
        do_op(3'd7, 3'd7, lat, pv, sv);
        chk("t2_lat", lat, 4);
        chk("t2_p", pv, 49);
        repeat (10) @(negedge clk);
        chk("t2_hold", p, 49);

        // Zero operands
        do_op(3'd5, 3'd0, lat, pv, sv);
        chk("t3a_lat", lat, 4);
        chk("t3a_p", pv, 0);
        do_op(3'd0, 3'd6, lat, pv, sv);
        chk("t3b_lat", lat, 4);
        chk("t3b_p", pv, 0);

        // start held high: 3*5 then 6*2, operands disturbed mid-RUN
        @(negedge clk);
        x     = 3'd3;
        y     = 3'd5;
        start = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rdy !== 1'b1 && lat < 20);
        chk("t4a_lat", lat, 4);
        chk("t4a_p", p, 15);
        x   = 3'd6;
        y   = 3'd2;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                x     = 3'd1;
                y     = 3'd1;
                start = 1'b0;
            end
        end while (rdy !== 1'b1 && lat < 20);
        chk("t4b_spacing", lat, 5);
        chk("t4b_p", p, 12);
        repeat (3) @(negedge clk);

        // Reset on the second RUN edge aborts 7*3
        x     = 3'd7;
        y     = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_p", p, 0);
        chk("t5_rdy", rdy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_rdy", rdy, 0);
        end
        do_op(3'd2, 3'd3, lat, pv, sv);
        chk("t5_lat", lat, 4);
        chk("t5_after_p", pv, 6);

        // Sign-magnitude vectors (plain unsigned products in the default build)
        do_op(3'b111, 3'b010, lat, pv, sv);
`ifdef MUL_SIGNED_EN
        chk("t6a_p", pv, 6);
        chk("t6a_s", sv, 1);
`else
        chk("t6a_p", pv, 14);
        chk("t6a_s", sv, 0);
`endif
        do_op(3'b100, 3'b011, lat, pv, sv);
`ifdef MUL_SIGNED_EN
        chk("t6b_p", pv, 0);
        chk("t6b_s", sv, 0);
`else
        chk("t6b_p", pv, 12);
        chk("t6b_s", sv, 0);
`endif
        do_op(3'b101, 3'b110, lat, pv, sv);
`ifdef MUL_SIGNED_EN
        chk("t6c_p", pv, 2);
        chk("t6c_s", sv, 0);
`else
        chk("t6c_p", pv, 30);
        chk("t6c_s", sv, 0);
`endif
        chk("t6_lat", lat, 4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
